// File: rtl/pm16_mac_acc.sv
`default_nettype none
// ============================================================================
// Module   : pm16_mac_acc
// Purpose  : Frame accumulator placed after the pm16 16x16 unsigned multiplier.
//            Sums `len` products per frame over a valid/ready input, then
//            offers the registered sum and a sticky carry-out flag over a
//            valid/ready output. The pair forms a MAC / dot-product stage.
// Revision : 1.0  initial release
// ============================================================================
module pm16_mac_acc #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              busy
);

    // IDLE waits for a first product, ACCUM sums the rest of the frame,
    // HOLD presents the result until downstream takes it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len_lat;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W:0]   w_sum;
    logic [LEN_W-1:0] w_len_eff;
    logic [LEN_W:0]   w_cnt_next;
    logic             w_accept;

    // Zero-extend the product to the accumulator width; the equal-width case
    // needs no padding (a zero-width replication is illegal).
    generate
        if (ACC_W > PROD_W) begin : g_zext_pad
            assign w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod};
        end else begin : g_zext_none
            assign w_prod_ext = prod[ACC_W-1:0];
        end
    endgenerate

    // The extra top bit of the sum is the carry out of the accumulator.
    assign w_sum      = {1'b0, acc_out} + {1'b0, w_prod_ext};
    // A zero length is treated as a one-product frame.
    assign w_len_eff  = (len == '0) ? LEN_W'(1) : len;
    // One bit wider than the counter so the compare cannot alias on wrap.
    assign w_cnt_next = {1'b0, r_cnt} + (LEN_W+1)'(1);

    assign in_ready   = (r_state != ST_HOLD);
    assign w_accept   = in_valid & in_ready;

    // Frame state machine with registered result, flag and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_len_lat <= '0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            // Abort: any product arriving with clear is dropped.
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // First product loads rather than adds.
                        r_len_lat <= w_len_eff;
                        acc_out   <= w_prod_ext;
                        ovf       <= 1'b0;
                        r_cnt     <= LEN_W'(1);
                        if (w_len_eff == LEN_W'(1)) begin
                            r_state   <= ST_HOLD;
                            out_valid <= 1'b1;
                        end else begin
                            r_state   <= ST_ACCUM;
                            busy      <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_accept) begin
                        acc_out <= w_sum[ACC_W-1:0];
                        ovf     <= ovf | w_sum[ACC_W];
                        r_cnt   <= w_cnt_next[LEN_W-1:0];
                        if (w_cnt_next == {1'b0, r_len_lat}) begin
                            r_state   <= ST_HOLD;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
